// File: rtl/jpeg_izigzag_buf.sv
// Inverse zig-zag reorder buffer: zig-zag ordered 8x8 coefficient blocks in, raster order out.
// Two ping-pong banks let one block be written while the previous one is drained.
`timescale 1ns/1ps
module jpeg_izigzag_buf #(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_first,
    output logic          dout_last
);

    // Raster position of each zig-zag index (ITU-T T.81 Fig. A.6)
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [DW-1:0] r_mem [2][64];
    logic [1:0]    r_full;
    logic          r_wbank;
    logic [5:0]    r_wcnt;
    logic          r_rbank;
    logic [5:0]    r_rcnt;
    logic [DW-1:0] r_dout;
    logic          r_dout_valid;
    logic          r_dout_first;
    logic          r_dout_last;

    logic          w_acc;
    logic          w_wlast;
    logic          w_load;
    logic          w_rlast;
    logic [1:0]    w_full_nxt;
    logic [DW-1:0] w_rdata;

    assign din_ready = !r_full[r_wbank];
    assign w_acc     = din_valid && din_ready;
    assign w_wlast   = w_acc && (r_wcnt == 6'd63);
    assign w_load    = r_full[r_rbank] && (!r_dout_valid || dout_ready);
    assign w_rlast   = w_load && (r_rcnt == 6'd63);
    assign w_rdata   = r_mem[r_rbank][r_rcnt];

    // Set and clear never hit the same bank: a full write bank blocks writes.
    always_comb begin
        w_full_nxt = r_full;
        if (w_rlast)
            w_full_nxt[r_rbank] = 1'b0;
        if (w_wlast)
            w_full_nxt[r_wbank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_acc)
            r_mem[r_wbank][ZZ[r_wcnt]] <= din;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_full       <= 2'b00;
            r_wbank      <= 1'b0;
            r_wcnt       <= 6'd0;
            r_rbank      <= 1'b0;
            r_rcnt       <= 6'd0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_first <= 1'b0;
            r_dout_last  <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_acc) begin
                r_wcnt <= r_wcnt + 6'd1;
                if (w_wlast)
                    r_wbank <= ~r_wbank;
            end
            if (w_load) begin
                r_dout       <= w_rdata;
                r_dout_valid <= 1'b1;
                r_dout_first <= (r_rcnt == 6'd0);
                r_dout_last  <= (r_rcnt == 6'd63);
                r_rcnt       <= r_rcnt + 6'd1;
                if (w_rlast)
                    r_rbank <= ~r_rbank;
            end else if (dout_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_first = r_dout_first;
    assign dout_last  = r_dout_last;

endmodule

// File: tb/tb_jpeg_izigzag_buf.sv
// Bench for jpeg_izigzag_buf: directed blocks feed a raster-order scoreboard drained by a monitor.
`timescale 1ns/1ps
module tb_jpeg_izigzag_buf;

    typedef logic [11:0] blk_t [64];
    typedef struct packed {
        logic [11:0] d;
        logic        f;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic [11:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [11:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_first;
    logic        dout_last;

    logic [15:0] din16;
    logic        din_valid16;
    logic        din_ready16;
    logic [15:0] dout16;
    logic        dout_valid16;
    logic        dout_ready16;
    logic        dout_first16;
    logic        dout_last16;

    always #5 clk = ~clk;

    jpeg_izigzag_buf #(.DW(12)) u_dut (
        .clk(clk), .nrst(nrst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_first(dout_first), .dout_last(dout_last)
    );

    jpeg_izigzag_buf #(.DW(16)) u_dut16 (
        .clk(clk), .nrst(nrst), .din(din16), .din_valid(din_valid16), .din_ready(din_ready16),
        .dout(dout16), .dout_valid(dout_valid16), .dout_ready(dout_ready16),
        .dout_first(dout_first16), .dout_last(dout_last16)
    );

    exp_t        sb_q [$];
    logic [11:0] obs_q [$];
    int n_checks = 0;
    int n_errors = 0;
    int rdy_mode = 1;
    int acc_cnt  = 0;
    int stall_cnt = 0;
    int run = 0;
    int max_run = 0;
    bit bp_done = 0;
    int zzpos [64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Zig-zag walk built from the diagonal traversal rather than a table.
    task automatic build_zz();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zzpos[k] = r * 8 + (s - r); k++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zzpos[k] = r * 8 + (s - r); k++; end
            end
        end
    endtask

    task automatic expect_block(input blk_t v);
        logic [11:0] ras [64];
        exp_t e;
        for (int k = 0; k < 64; k++) ras[zzpos[k]] = v[k];
        for (int r = 0; r < 64; r++) begin
            e.d = ras[r];
            e.f = (r == 0);
            e.l = (r == 63);
            sb_q.push_back(e);
        end
    endtask

    task automatic send_coef(input logic [11:0] v, input bit rnd);
        int  t = 0;
        bit  done = 0;
        while (!done) begin
            if (rnd && $urandom_range(1) == 0) begin
                din_valid = 1'b0;
                @(posedge clk); #1;
            end else begin
                din = v;
                din_valid = 1'b1;
                @(negedge clk);
                done = din_ready;
                if (!din_ready) stall_cnt++;
                @(posedge clk); #1;
                if (done) acc_cnt++;
            end
            t++;
            if (!done && t > 3000) begin
                n_checks++;
                n_errors++;
                $display("FAIL accept_timeout: got 0 accepts expected 1");
                done = 1;
            end
        end
    endtask

    task automatic send_block(input blk_t v, input bit rnd);
        expect_block(v);
        for (int k = 0; k < 64; k++) send_coef(v[k], rnd);
        din_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d left expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       dout_ready = 1'b0;
            1:       dout_ready = 1'b1;
            default: dout_ready = 1'($urandom_range(1));
        endcase
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (nrst === 1'b1) begin
            if (dout_valid) run++; else run = 0;
            if (run > max_run) max_run = run;
            if (dout_valid && dout_ready) begin
                obs_q.push_back(dout);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: got %0d expected no output", dout);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_data", dout, e.d);
                    check("sb_first", dout_first, e.f);
                    check("sb_last", dout_last, e.l);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t v;
        logic [15:0] q16 [$];
        int t;
        int hand [11] = '{0, 1, 5, 6, 14, 15, 27, 28, 2, 3, 63};
        int hpos [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 16, 63};

        build_zz();
        nrst = 1'b0;
        din = '0; din_valid = 1'b0;
        din16 = '0; din_valid16 = 1'b0; dout_ready16 = 1'b1;
        #12;
        check("rst_din_ready", din_ready, 1);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_dout_first", dout_first, 0);
        check("rst_dout_last", dout_last, 0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;

        // Single block, data = zig-zag index
        rdy_mode = 1;
        obs_q.delete();
        for (int k = 0; k < 64; k++) v[k] = 12'(k);
        send_block(v, 0);
        @(negedge clk);
        check("latency_n1_valid", dout_valid, 0);
        @(negedge clk);
        check("latency_n2_valid", dout_valid, 1);
        drain();
        check("single_count", obs_q.size(), 64);
        if (obs_q.size() == 64)
            for (int i = 0; i < 11; i++) check("single_hand", obs_q[hpos[i]], 12'(hand[i]));

        // Streaming four blocks
        repeat (3) @(posedge clk);
        #1;
        stall_cnt = 0;
        max_run = 0;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 64; k++) v[k] = 12'(b * 100 + k);
            send_block(v, 0);
        end
        drain();
        check("stream_no_stall", stall_cnt, 0);
        check("stream_run", max_run, 256);

        // Backpressure: three blocks, output stalled
        repeat (3) @(posedge clk);
        #1;
        rdy_mode = 0;
        acc_cnt = 0;
        bp_done = 0;
        fork
            begin
                blk_t vb;
                for (int b = 0; b < 3; b++) begin
                    for (int k = 0; k < 64; k++) vb[k] = 12'(b * 400 + k);
                    send_block(vb, 0);
                end
                bp_done = 1;
            end
        join_none
        t = 0;
        while (acc_cnt < 128 && t < 1000) begin @(negedge clk); t++; end
        @(negedge clk);
        check("bp_ready_fall", din_ready, 0);
        repeat (20) @(negedge clk);
        check("bp_accepts", acc_cnt, 128);
        check("bp_ready_low", din_ready, 0);
        check("bp_hold_valid", dout_valid, 1);
        check("bp_hold_data", dout, 0);
        check("bp_hold_first", dout_first, 1);
        @(posedge clk); #1;
        rdy_mode = 1;
        t = 0;
        while (!bp_done && t < 3000) begin @(negedge clk); t++; end
        check("bp_block3_done", bp_done, 1);
        drain();
        check("bp_total_accepts", acc_cnt, 192);

        // Random stalls
        @(posedge clk); #1;
        rdy_mode = 2;
        for (int b = 0; b < 20; b++) begin
            for (int k = 0; k < 64; k++) v[k] = 12'($urandom);
            send_block(v, 1);
        end
        drain();
        rdy_mode = 1;

        // Reset mid-operation
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 64; k++) v[k] = 12'(50 + k);
        send_block(v, 0);
        for (int k = 0; k < 30; k++) send_coef(12'(900 + k), 0);
        din_valid = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        check("mid_rst_valid", dout_valid, 0);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_first", dout_first, 0);
        check("mid_rst_last", dout_last, 0);
        check("mid_rst_ready", din_ready, 1);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        obs_q.delete();
        for (int k = 0; k < 64; k++) v[k] = 12'(700 + k);
        send_block(v, 0);
        drain();
        check("post_rst_count", obs_q.size(), 64);
        if (obs_q.size() > 0) check("post_rst_raster0", obs_q[0], 700);

        // DW = 16 extremes
        for (int k = 0; k < 64; k++) begin
            din16 = (k == 0) ? 16'h8000 : (k == 63) ? 16'h7fff : 16'(k);
            din_valid16 = 1'b1;
            @(posedge clk); #1;
        end
        din_valid16 = 1'b0;
        t = 0;
        while (q16.size() < 64 && t < 300) begin
            @(negedge clk);
            if (dout_valid16) q16.push_back(dout16);
            t++;
        end
        check("w16_count", q16.size(), 64);
        if (q16.size() == 64) begin
            check("w16_raster0", q16[0], 16'h8000);
            check("w16_raster1", q16[1], 16'd1);
            check("w16_raster63", q16[63], 16'h7fff);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
